// File: rtl/spi_receiver.sv
// SPI slave receiver/transmitter running in the system clock domain.
// SCK, CS and MOSI are oversampled through 2-FF synchronizers; supports all CKP/CPH modes.
module spi_receiver #(
    parameter int   WIDTH     = 16,
    parameter logic IDLE_MISO = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CKP,
    input  logic             CPH,
    input  logic             SCK,
    input  logic             CS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

    state_t           r_state;
    logic             r_sck_s1, r_sck_s2, r_sck_d;
    logic             r_cs_s1, r_cs_s2, r_cs_d;
    logic             r_mosi_s1, r_mosi_s2;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rx_shift, r_tx_shift;
    logic             r_first;

    logic w_lead, w_trail, w_samp, w_shft, w_cs_rise;

    // SCK is synchronized relative to its idle level (SCK ^ CKP), so a reset
    // value of 0 means "at CKP" and the leading edge is always a 0->1 step.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sck_s1  <= 1'b0;
            r_sck_s2  <= 1'b0;
            r_sck_d   <= 1'b0;
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_cs_d    <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_sck_s1  <= SCK ^ CKP;
            r_sck_s2  <= r_sck_s1;
            r_sck_d   <= r_sck_s2;
            r_cs_s1   <= CS;
            r_cs_s2   <= r_cs_s1;
            r_cs_d    <= r_cs_s2;
            r_mosi_s1 <= MOSI;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_lead    = r_sck_s2 & ~r_sck_d;
    assign w_trail   = ~r_sck_s2 & r_sck_d;
    assign w_samp    = CPH ? w_trail : w_lead;
    assign w_shft    = CPH ? w_lead : w_trail;
    assign w_cs_rise = r_cs_s2 & ~r_cs_d;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_first    <= 1'b0;
            MISO       <= IDLE_MISO;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                // Start on CS level so a CS that fell during DONE is not lost.
                S_IDLE: begin
                    MISO <= IDLE_MISO;
                    if (!r_cs_s2) begin
                        r_tx_shift <= tx_data;
                        r_cnt      <= '0;
                        r_first    <= 1'b1;
                        busy       <= 1'b1;
                        r_state    <= S_ACTIVE;
                        if (!CPH) MISO <= tx_data[WIDTH-1];
                    end
                end
                S_ACTIVE: begin
                    if (w_cs_rise) begin
                        r_state <= S_DONE;
                    end else if (w_samp) begin
                        r_rx_shift <= {r_rx_shift[WIDTH-2:0], r_mosi_s2};
                        if (r_cnt != CW'(WIDTH + 1)) r_cnt <= r_cnt + 1'b1;
                    end else if (w_shft) begin
                        // CPH=1: the first leading edge only presents the MSB.
                        if (CPH && r_first) begin
                            MISO    <= r_tx_shift[WIDTH-1];
                            r_first <= 1'b0;
                        end else begin
                            r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
                            MISO       <= r_tx_shift[WIDTH-2];
                        end
                    end
                end
                S_DONE: begin
                    if (r_cnt == CW'(WIDTH)) begin
                        rx_data  <= r_rx_shift;
                        rx_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    busy    <= 1'b0;
                    MISO    <= IDLE_MISO;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_receiver.sv
// Scoreboard bench for spi_receiver: directed frames in all SPI modes, errors,
// mid-frame reset and back-to-back frames.
module tb_spi_receiver;

    logic        CLK, RESET, CKP, CPH, SCK, CS, MOSI, MISO;
    logic [15:0] tx_data, rx_data;
    logic        rx_valid, busy, frame_err;

    typedef struct {
        logic        err;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          cs_rise_cyc = 0;
    logic [15:0] last_rx = 16'h0;
    logic [15:0] mw;

    spi_receiver #(.WIDTH(16), .IDLE_MISO(1'b0)) dut (
        .CLK(CLK), .RESET(RESET), .CKP(CKP), .CPH(CPH), .SCK(SCK), .CS(CS),
        .MOSI(MOSI), .MISO(MISO), .tx_data(tx_data), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: pops one expectation per rx_valid / frame_err pulse.
    always @(negedge CLK) begin
        if (RESET && (rx_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b, expected none", rx_valid, frame_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_kind", {rx_valid, frame_err}, e.err ? 2'b01 : 2'b10);
                chk("rx_data", rx_data, e.data);
                if (!e.err) chk("latency", cyc - cs_rise_cyc, 4);
            end
        end
    end

    // Master side of one frame; tx_data is scrambled mid-frame to show it is ignored.
    task automatic frame(input logic [31:0] w, input int nb, input int gap, output logic [15:0] miso_w);
        miso_w = '0;
        SCK = CKP;
        if (!CPH) MOSI = w[nb-1];
        CS = 1'b0;
        wclk(4);
        for (int i = 0; i < nb; i++) begin
            if (i == nb / 2) tx_data = 16'hDEAD;
            if (!CPH) begin
                MOSI = w[nb-1-i];
                wclk(4);
                miso_w = {miso_w[14:0], MISO};
                SCK = ~CKP;
                wclk(4);
                SCK = CKP;
            end else begin
                SCK = ~CKP;
                MOSI = w[nb-1-i];
                wclk(4);
                miso_w = {miso_w[14:0], MISO};
                SCK = CKP;
                wclk(4);
            end
        end
        wclk(4);
        CS = 1'b1;
        cs_rise_cyc = cyc;
        wclk(gap);
    endtask

    task automatic drain(input string nm);
        wclk(12);
        #1;
        chk(nm, exp_q.size(), 0);
        exp_q.delete();
        chk({nm, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b0; CKP = 1'b0; CPH = 1'b0; SCK = 1'b0; CS = 1'b1; MOSI = 1'b0; tx_data = 16'h0;
        wclk(3);
        chk("rst_miso", MISO, 1'b0);
        chk("rst_rx_data", rx_data, 16'h0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        RESET = 1'b1;
        wclk(4);

        // SCK activity with CS high must be ignored.
        repeat (3) begin
            SCK = 1'b1; wclk(4); SCK = 1'b0; wclk(4);
        end
        chk("idle_sck_busy", busy, 1'b0);

        for (int m = 0; m < 4; m++) begin
            CKP = m[1]; CPH = m[0]; SCK = m[1];
            wclk(4);
            tx_data = 16'h0062;
            exp_q.push_back('{err: 1'b0, data: 16'h0015});
            frame(32'h0015, 16, 8, mw);
            chk($sformatf("miso_mode%0d", m), mw, 16'h0062);
            drain($sformatf("drain_mode%0d", m));
        end
        last_rx = 16'h0015;

        // Short frame: 8 bits.
        CKP = 1'b0; CPH = 1'b0; SCK = 1'b0;
        wclk(4);
        exp_q.push_back('{err: 1'b1, data: last_rx});
        frame(32'hA5, 8, 8, mw);
        drain("drain_short");

        // Reset after 5 bits of a frame.
        tx_data = 16'h0062;
        CS = 1'b0;
        wclk(4);
        for (int i = 0; i < 5; i++) begin
            MOSI = i[0]; wclk(4); SCK = 1'b1; wclk(4); SCK = 1'b0;
        end
        wclk(2);
        chk("pre_rst_busy", busy, 1'b1);
        RESET = 1'b0;
        #1;
        chk("mid_rst_miso", MISO, 1'b0);
        chk("mid_rst_rx_data", rx_data, 16'h0);
        chk("mid_rst_rx_valid", rx_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_frame_err", frame_err, 1'b0);
        CS = 1'b1; SCK = 1'b0;
        wclk(3);
        RESET = 1'b1;
        wclk(4);
        exp_q.push_back('{err: 1'b0, data: 16'h1234});
        frame(32'h1234, 16, 8, mw);
        chk("miso_after_rst", mw, 16'h0062);
        drain("drain_after_rst");
        last_rx = 16'h1234;

        // Back-to-back frames with 3 CLK of CS high between them.
        CKP = 1'b1; CPH = 1'b1; SCK = 1'b1;
        wclk(4);
        exp_q.push_back('{err: 1'b0, data: 16'hBEEF});
        exp_q.push_back('{err: 1'b0, data: 16'h0F0F});
        tx_data = 16'hA55A;
        frame(32'hBEEF, 16, 3, mw);
        chk("miso_b2b_0", mw, 16'hA55A);
        tx_data = 16'h3C96;
        frame(32'h0F0F, 16, 8, mw);
        chk("miso_b2b_1", mw, 16'h3C96);
        drain("drain_b2b");
        last_rx = 16'h0F0F;

        // Overlong frame: 17 bits.
        exp_q.push_back('{err: 1'b1, data: last_rx});
        frame(32'h1FFFF, 17, 8, mw);
        drain("drain_long");
        chk("long_rx_data", rx_data, last_rx);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
